ctrl_pipe: RTL and testbench

Pipelined control unit for the 16-bit, 4-bit-opcode core. It decodes the instruction held in IF/ID and carries the control bundle through registered EX, MEM and WB stages. It also detects load-use hazards, generates the IF/ID flush on taken branches, and sequences HLT so the pipeline drains before the core reports halted. It sits between the IF/ID register and the datapath stage registers, and replaces the purely combinational decoder.

---
 rtl/ctrl_pipe.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit for the 16-bit, 4-bit-opcode core.
// Decodes the IF/ID instruction, carries the control bundle through EX/MEM/WB,
// detects load-use hazards, generates the branch flush and drains the pipe on HLT.
`timescale 1ns/1ps
module ctrl_pipe #(
  parameter int unsigned REGW      = 4,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [3:0]      opcode,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic [REGW-1:0] id_dst,
  input  logic            branch_taken,
  input  logic            stall_ext,
  output logic            stall_o,
  output logic            flush_o,
  output logic            ex_valid,
  output logic            ex_alu_src,
  output logic            ex_lb,
  output logic [3:0]      ex_alu_op,
  output logic [REGW-1:0] ex_dst,
  output logic            mem_valid,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_en,
  output logic [REGW-1:0] mem_dst,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic            wb_mem_to_reg,
  output logic            wb_pcs,
  output logic [REGW-1:0] wb_dst,
  output logic            halted
);

  localparam logic [3:0] OpAdd    = 4'h0;
  localparam logic [3:0] OpSub    = 4'h1;
  localparam logic [3:0] OpXor    = 4'h2;
  localparam logic [3:0] OpRed    = 4'h3;
  localparam logic [3:0] OpSll    = 4'h4;
  localparam logic [3:0] OpSra    = 4'h5;
  localparam logic [3:0] OpRor    = 4'h6;
  localparam logic [3:0] OpPaddsb = 4'h7;
  localparam logic [3:0] OpLw     = 4'h8;
  localparam logic [3:0] OpSw     = 4'h9;
  localparam logic [3:0] OpLlb    = 4'hA;
  localparam logic [3:0] OpLhb    = 4'hB;
  localparam logic [3:0] OpB      = 4'hC;
  localparam logic [3:0] OpBr     = 4'hD;
  localparam logic [3:0] OpPcs    = 4'hE;
  localparam logic [3:0] OpHlt    = 4'hF;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e state_q, state_d;
  logic   halted_q, halted_d;

  // EX stage
  logic            ex_valid_q, ex_valid_d;
  logic            ex_alu_src_q, ex_alu_src_d;
  logic            ex_lb_q, ex_lb_d;
  logic [3:0]      ex_alu_op_q, ex_alu_op_d;
  logic [REGW-1:0] ex_dst_q, ex_dst_d;
  logic            ex_mem_read_q, ex_mem_read_d;
  logic            ex_mem_write_q, ex_mem_write_d;
  logic            ex_reg_write_q, ex_reg_write_d;
  logic            ex_pcs_q, ex_pcs_d;
  logic            ex_hlt_q, ex_hlt_d;
  // MEM stage
  logic            mem_valid_q, mem_valid_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            mem_en_q, mem_en_d;
  logic [REGW-1:0] mem_dst_q, mem_dst_d;
  logic            mem_reg_write_q, mem_reg_write_d;
  logic            mem_pcs_q, mem_pcs_d;
  logic            mem_hlt_q, mem_hlt_d;
  // WB stage
  logic            wb_valid_q, wb_valid_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic            wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic            wb_pcs_q, wb_pcs_d;
  logic [REGW-1:0] wb_dst_q, wb_dst_d;
  logic            wb_hlt_q, wb_hlt_d;

  logic dec_alu_src, dec_mem_read, dec_mem_write, dec_lb, dec_pcs, dec_hlt, dec_reg_write;
  logic reads_rs, reads_rt, load_use, accept;

  // Decode the IF/ID opcode into the control bundle and operand usage.
  always_comb begin
    dec_alu_src   = opcode inside {OpLw, OpSw, OpSll, OpSra, OpRor};
    dec_mem_read  = (opcode == OpLw);
    dec_mem_write = (opcode == OpSw);
    dec_lb        = opcode inside {OpLlb, OpLhb};
    dec_pcs       = (opcode == OpPcs);
    dec_hlt       = (opcode == OpHlt);
    // R0 is hardwired, so writes to it are dropped here.
    dec_reg_write = !(opcode inside {OpB, OpBr, OpHlt, OpSw}) && (id_dst != '0);
    reads_rs      = !(opcode inside {OpLlb, OpLhb, OpB, OpPcs, OpHlt});
    reads_rt      = opcode inside {OpAdd, OpSub, OpXor, OpRed, OpPaddsb, OpSw};
  end

  // Hazard, stall and flush generation; IF/ID is ignored outside RUN.
  always_comb begin
    load_use = 1'b0;
    if (HAZARD_EN && (state_q == StRun) && ex_valid_q && ex_mem_read_q &&
        (ex_dst_q != '0) && id_valid) begin
      load_use = (reads_rs && (ex_dst_q == id_rs)) || (reads_rt && (ex_dst_q == id_rt));
    end
    stall_o = load_use || (state_q != StRun);
    flush_o = branch_taken && id_valid && !stall_o && !stall_ext;
    accept  = id_valid && !stall_o;
  end

  // Next state for the stage registers and the halt FSM.
  always_comb begin
    state_d         = state_q;
    halted_d        = halted_q;
    ex_valid_d      = ex_valid_q;
    ex_alu_src_d    = ex_alu_src_q;
    ex_lb_d         = ex_lb_q;
    ex_alu_op_d     = ex_alu_op_q;
    ex_dst_d        = ex_dst_q;
    ex_mem_read_d   = ex_mem_read_q;
    ex_mem_write_d  = ex_mem_write_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_pcs_d        = ex_pcs_q;
    ex_hlt_d        = ex_hlt_q;
    mem_valid_d     = mem_valid_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_en_d        = mem_en_q;
    mem_dst_d       = mem_dst_q;
    mem_reg_write_d = mem_reg_write_q;
    mem_pcs_d       = mem_pcs_q;
    mem_hlt_d       = mem_hlt_q;
    wb_valid_d      = wb_valid_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_pcs_d        = wb_pcs_q;
    wb_dst_d        = wb_dst_q;
    wb_hlt_d        = wb_hlt_q;

    if (!stall_ext) begin
      // Bubble unless a real instruction is accepted.
      ex_valid_d     = 1'b0;
      ex_alu_src_d   = 1'b0;
      ex_lb_d        = 1'b0;
      ex_alu_op_d    = '0;
      ex_dst_d       = '0;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_pcs_d       = 1'b0;
      ex_hlt_d       = 1'b0;
      if (accept) begin
        ex_valid_d     = 1'b1;
        ex_alu_src_d   = dec_alu_src;
        ex_lb_d        = dec_lb;
        ex_alu_op_d    = opcode;
        ex_dst_d       = id_dst;
        ex_mem_read_d  = dec_mem_read;
        ex_mem_write_d = dec_mem_write;
        ex_reg_write_d = dec_reg_write;
        ex_pcs_d       = dec_pcs;
        ex_hlt_d       = dec_hlt;
      end

      mem_valid_d     = ex_valid_q;
      mem_read_d      = ex_mem_read_q;
      mem_write_d     = ex_mem_write_q;
      mem_en_d        = ex_mem_read_q | ex_mem_write_q;
      mem_dst_d       = ex_dst_q;
      mem_reg_write_d = ex_reg_write_q;
      mem_pcs_d       = ex_pcs_q;
      mem_hlt_d       = ex_hlt_q;

      wb_valid_d      = mem_valid_q;
      wb_reg_write_d  = mem_reg_write_q;
      wb_mem_to_reg_d = mem_read_q;
      wb_pcs_d        = mem_pcs_q;
      wb_dst_d        = mem_dst_q;
      wb_hlt_d        = mem_hlt_q;

      unique case (state_q)
        StRun: begin
          if (accept && dec_hlt) state_d = StDrain;
        end
        StDrain: begin
          // halted rises on the edge that moves HLT into WB.
          if (mem_hlt_q) halted_d = 1'b1;
          if (wb_hlt_q)  state_d  = StHalted;
        end
        StHalted: begin
          state_d = StHalted;
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Stage registers and halt FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StRun;
      halted_q        <= 1'b0;
      ex_valid_q      <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_lb_q         <= 1'b0;
      ex_alu_op_q     <= '0;
      ex_dst_q        <= '0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_pcs_q        <= 1'b0;
      ex_hlt_q        <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_en_q        <= 1'b0;
      mem_dst_q       <= '0;
      mem_reg_write_q <= 1'b0;
      mem_pcs_q       <= 1'b0;
      mem_hlt_q       <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_pcs_q        <= 1'b0;
      wb_dst_q        <= '0;
      wb_hlt_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      halted_q        <= halted_d;
      ex_valid_q      <= ex_valid_d;
      ex_alu_src_q    <= ex_alu_src_d;
      ex_lb_q         <= ex_lb_d;
      ex_alu_op_q     <= ex_alu_op_d;
      ex_dst_q        <= ex_dst_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_pcs_q        <= ex_pcs_d;
      ex_hlt_q        <= ex_hlt_d;
      mem_valid_q     <= mem_valid_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_en_q        <= mem_en_d;
      mem_dst_q       <= mem_dst_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_pcs_q       <= mem_pcs_d;
      mem_hlt_q       <= mem_hlt_d;
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_pcs_q        <= wb_pcs_d;
      wb_dst_q        <= wb_dst_d;
      wb_hlt_q        <= wb_hlt_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_alu_src    = ex_alu_src_q;
  assign ex_lb         = ex_lb_q;
  assign ex_alu_op     = ex_alu_op_q;
  assign ex_dst        = ex_dst_q;
  assign mem_valid     = mem_valid_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_en        = mem_en_q;
  assign mem_dst       = mem_dst_q;
  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_pcs        = wb_pcs_q;
  assign wb_dst        = wb_dst_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed bench for ctrl_pipe with a WB scoreboard.
// A second instance with HAZARD_EN=0 shares the inputs for the no-stall case.
`timescale 1ns/1ps
module tb_ctrl_pipe;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] opcode, id_rs, id_rt, id_dst;
  logic       branch_taken, stall_ext;

  logic       stall_o, flush_o, ex_valid, ex_alu_src, ex_lb;
  logic [3:0] ex_alu_op, ex_dst, mem_dst, wb_dst;
  logic       mem_valid, mem_read, mem_write, mem_en;
  logic       wb_valid, wb_reg_write, wb_mem_to_reg, wb_pcs, halted;

  logic       h0_stall_o, h0_flush_o, h0_ex_valid, h0_ex_alu_src, h0_ex_lb;
  logic [3:0] h0_ex_alu_op, h0_ex_dst, h0_mem_dst, h0_wb_dst;
  logic       h0_mem_valid, h0_mem_read, h0_mem_write, h0_mem_en;
  logic       h0_wb_valid, h0_wb_reg_write, h0_wb_mem_to_reg, h0_wb_pcs, h0_halted;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [6:0]  sb_q[$];

  ctrl_pipe #(.REGW(4), .HAZARD_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .branch_taken(branch_taken), .stall_ext(stall_ext),
    .stall_o(stall_o), .flush_o(flush_o),
    .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_lb(ex_lb),
    .ex_alu_op(ex_alu_op), .ex_dst(ex_dst),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_en(mem_en), .mem_dst(mem_dst),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_pcs(wb_pcs), .wb_dst(wb_dst), .halted(halted)
  );

  ctrl_pipe #(.REGW(4), .HAZARD_EN(1'b0)) u_dut_nohz (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .branch_taken(branch_taken), .stall_ext(stall_ext),
    .stall_o(h0_stall_o), .flush_o(h0_flush_o),
    .ex_valid(h0_ex_valid), .ex_alu_src(h0_ex_alu_src), .ex_lb(h0_ex_lb),
    .ex_alu_op(h0_ex_alu_op), .ex_dst(h0_ex_dst),
    .mem_valid(h0_mem_valid), .mem_read(h0_mem_read), .mem_write(h0_mem_write),
    .mem_en(h0_mem_en), .mem_dst(h0_mem_dst),
    .wb_valid(h0_wb_valid), .wb_reg_write(h0_wb_reg_write),
    .wb_mem_to_reg(h0_wb_mem_to_reg), .wb_pcs(h0_wb_pcs), .wb_dst(h0_wb_dst),
    .halted(h0_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected WB bundle {reg_write, mem_to_reg, pcs, dst} from the opcode table.
  function automatic logic [6:0] exp_wb(input logic [3:0] op, input logic [3:0] dst);
    logic rw;
    rw = !(op inside {4'hC, 4'hD, 4'hF, 4'h9}) && (dst != 4'h0);
    return {rw, op == 4'h8, op == 4'hE, dst};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [3:0] dst,
                       input logic bt, input logic se);
    id_valid     = v;
    opcode       = op;
    id_rs        = rs;
    id_rt        = rt;
    id_dst       = dst;
    branch_taken = bt;
    stall_ext    = se;
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] dst);
    sb_q.push_back(exp_wb(op, dst));
  endtask

  // One clock edge; a fresh WB instruction is popped and compared.
  task automatic tick();
    logic       frz;
    logic [6:0] e;
    frz = stall_ext;
    @(posedge clk);
    #1;
    if (!frz && wb_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_wb", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_wb", {25'd0, wb_reg_write, wb_mem_to_reg, wb_pcs, wb_dst}, {25'd0, e});
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    #3;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_halted", halted, 0);
    chk("rst_wb_dst", wb_dst, 0);
    chk("rst_mem_valid", mem_valid, 0);
    #9 rst_n = 1'b1;

    // ADD R3
    drive(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0);
    push(4'h0, 4'h3);
    tick();
    chk("add_ex_valid", ex_valid, 1);
    chk("add_ex_alu_op", ex_alu_op, 4'h0);
    chk("add_ex_dst", ex_dst, 3);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    chk("add_mem_valid", mem_valid, 1);
    tick();
    chk("add_wb_reg_write", wb_reg_write, 1);
    chk("add_wb_dst", wb_dst, 3);

    // LW R2 then ADD R4,R2,R1: one-cycle load-use stall
    drive(1'b1, 4'h8, 4'h5, 4'h0, 4'h2, 1'b0, 1'b0);
    #1 chk("lw_no_stall", stall_o, 0);
    push(4'h8, 4'h2);
    tick();
    chk("lw_ex_alu_src", ex_alu_src, 1);
    drive(1'b1, 4'h0, 4'h2, 4'h1, 4'h4, 1'b0, 1'b0);
    #1;
    chk("hz_stall", stall_o, 1);
    chk("hz_off_no_stall", h0_stall_o, 0);
    tick();
    chk("hz_bubble", ex_valid, 0);
    chk("hz_stall_one_cycle", stall_o, 0);
    push(4'h0, 4'h4);
    tick();
    chk("hz_add_ex_valid", ex_valid, 1);
    chk("hz_add_ex_dst", ex_dst, 4);

    // LW R5 then LLB R7 using rs=5: LLB reads no register, no stall
    drive(1'b1, 4'h8, 4'h1, 4'h0, 4'h5, 1'b0, 1'b0);
    push(4'h8, 4'h5);
    tick();
    drive(1'b1, 4'hA, 4'h5, 4'h5, 4'h7, 1'b0, 1'b0);
    #1 chk("llb_no_stall", stall_o, 0);
    push(4'hA, 4'h7);
    tick();
    chk("llb_ex_lb", ex_lb, 1);

    // LW R0 then ADD using R0: no stall, LW write dropped
    drive(1'b1, 4'h8, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0);
    push(4'h8, 4'h0);
    tick();
    drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h4, 1'b0, 1'b0);
    #1 chk("r0_no_stall", stall_o, 0);
    push(4'h0, 4'h4);
    tick();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    chk("lw_r0_wb_reg_write", wb_reg_write, 0);
    chk("lw_r0_wb_mem_to_reg", wb_mem_to_reg, 1);
    tick();

    // Taken branch: flush masked by stall_ext, then asserted
    drive(1'b1, 4'hC, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    #1 chk("br_flush_ext", flush_o, 0);
    tick();
    chk("ext_freeze_ex", ex_valid, 0);
    drive(1'b1, 4'hC, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    #1 chk("br_flush", flush_o, 1);
    push(4'hC, 4'h0);
    tick();
    chk("br_ex_alu_op", ex_alu_op, 4'hC);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    tick();

    // HLT accepted at edge t
    drive(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    #1 chk("hlt_pre_stall", stall_o, 0);
    push(4'hF, 4'h0);
    tick();
    chk("hlt_stall_t", stall_o, 1);
    chk("hlt_halted_t", halted, 0);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    chk("hlt_halted_t1", halted, 0);
    tick();
    chk("hlt_halted_t2", halted, 1);
    chk("hlt_stall_t2", stall_o, 1);
    drive(1'b1, 4'h0, 4'h1, 4'h1, 4'h6, 1'b1, 1'b0);
    #1 chk("halted_no_flush", flush_o, 0);
    tick();
    chk("halted_ignores_id", ex_valid, 0);

    // Reset while HALTED, then SW
    #2 rst_n = 1'b0;
    #1;
    chk("rst_halted_clr", halted, 0);
    chk("rst_stall_clr", stall_o, 0);
    chk("rst_wb_valid_clr", wb_valid, 0);
    drive(1'b1, 4'h9, 4'h1, 4'h2, 4'h5, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    push(4'h9, 4'h5);
    tick();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    chk("sw_mem_write", mem_write, 1);
    chk("sw_mem_en", mem_en, 1);
    chk("sw_mem_read", mem_read, 0);
    tick();
    chk("sw_wb_reg_write", wb_reg_write, 0);

    // HLT with two frozen cycles in DRAIN
    drive(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    push(4'hF, 4'h0);
    tick();
    chk("hlt2_stall_t", stall_o, 1);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    tick();
    tick();
    chk("hlt2_halted_frozen", halted, 0);
    chk("hlt2_stall_frozen", stall_o, 1);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    chk("hlt2_halted_t3", halted, 0);
    tick();
    chk("hlt2_halted_t4", halted, 1);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
